// File: rtl/axi_r_addr_decoder.sv
// Read-path AR address decoder: routes one outstanding AR to a decoded slave port or the
// misroute port, then steers that target's R beats back to the master until RLAST.
module axi_r_addr_decoder #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int NUM_SLAVES     = 2,
  parameter logic [NUM_SLAVES*AXI_ADDR_WIDTH-1:0] SLV_BASE = {8'h40, 8'h00},
  parameter logic [NUM_SLAVES*AXI_ADDR_WIDTH-1:0] SLV_MASK = {8'hC0, 8'hC0},
  parameter int AXI_ARCHAN_WIDTH = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 8 + 3 + 2,
  parameter int AXI_RDCHAN_WIDTH = AXI_ID_WIDTH + AXI_DATA_WIDTH + 2 + 1
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [AXI_ARCHAN_WIDTH-1:0]            S_AXI_ARCH_i,
  input  logic                                   S_AXI_ARCH_VALID_i,
  output logic                                   S_AXI_ARCH_READY_o,
  output logic [AXI_RDCHAN_WIDTH-1:0]            S_AXI_RCH_o,
  output logic                                   S_AXI_RCH_VALID_o,
  input  logic                                   S_AXI_RCH_READY_i,
  output logic [NUM_SLAVES*AXI_ARCHAN_WIDTH-1:0] M_AXI_ARCH_o,
  output logic [NUM_SLAVES-1:0]                  M_AXI_ARCH_VALID_o,
  input  logic [NUM_SLAVES-1:0]                  M_AXI_ARCH_READY_i,
  input  logic [NUM_SLAVES*AXI_RDCHAN_WIDTH-1:0] M_AXI_RCH_i,
  input  logic [NUM_SLAVES-1:0]                  M_AXI_RCH_VALID_i,
  output logic [NUM_SLAVES-1:0]                  M_AXI_RCH_READY_o,
  output logic [AXI_ARCHAN_WIDTH-1:0]            E_AXI_ARCH_o,
  output logic                                   E_AXI_ARCH_VALID_o,
  input  logic                                   E_AXI_ARCH_READY_i,
  input  logic [AXI_RDCHAN_WIDTH-1:0]            E_AXI_RCH_i,
  input  logic                                   E_AXI_RCH_VALID_i,
  output logic                                   E_AXI_RCH_READY_o,
  output logic [7:0]                             MISROUTE_CNT_o
);

  localparam int IDX_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int ADDR_LSB  = 5;
  localparam int RLAST_BIT = AXI_ID_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RDATA = 2'd2
  } state_t;

  // Returns {hit, index}; walking downward lets the lowest matching index win.
  function automatic logic [IDX_W:0] decode_target(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]) ==
          SLV_BASE[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]) begin
        res = {1'b1, IDX_W'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t                        r_state;
  state_t                        w_next_state;
  logic                          r_ar_ready;
  logic [AXI_ARCHAN_WIDTH-1:0]   r_ar_payload;
  logic                          r_tgt_err;
  logic [IDX_W-1:0]              r_tgt_idx;
  logic [NUM_SLAVES-1:0]         r_m_ar_valid;
  logic                          r_e_ar_valid;
  logic [7:0]                    r_misroute_cnt;

  logic [IDX_W:0]                w_dec;
  logic                          w_dec_hit;
  logic [IDX_W-1:0]              w_dec_idx;
  logic                          w_ar_cap;
  logic                          w_ar_hs;
  logic                          w_r_last_hs;

  assign w_dec       = decode_target(S_AXI_ARCH_i[ADDR_LSB +: AXI_ADDR_WIDTH]);
  assign w_dec_hit   = w_dec[IDX_W];
  assign w_dec_idx   = w_dec[IDX_W-1:0];
  assign w_ar_cap    = (r_state == ST_IDLE) & S_AXI_ARCH_VALID_i & r_ar_ready;
  assign w_r_last_hs = S_AXI_RCH_VALID_o & S_AXI_RCH_READY_i & S_AXI_RCH_o[RLAST_BIT];

  // AR handshake with whichever target is currently selected
  always_comb begin
    w_ar_hs = 1'b0;
    if (r_tgt_err) begin
      w_ar_hs = r_e_ar_valid & E_AXI_ARCH_READY_i;
    end else begin
      w_ar_hs = |(r_m_ar_valid & M_AXI_ARCH_READY_i);
    end
  end

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; the misroute responder can finish its burst while its AR is still pending
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ar_cap) begin
          w_next_state = ST_ISSUE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (w_ar_hs && w_r_last_hs) begin
          w_next_state = ST_IDLE;
        end else if (w_ar_hs) begin
          w_next_state = ST_RDATA;
        end else begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_RDATA: begin
        if (w_r_last_hs) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RDATA;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic: zero-latency R mux from the selected target, active only outside IDLE
  always_comb begin
    S_AXI_RCH_o       = '0;
    S_AXI_RCH_VALID_o = 1'b0;
    M_AXI_RCH_READY_o = '0;
    E_AXI_RCH_READY_o = 1'b0;
    if (r_state == ST_IDLE) begin
      S_AXI_RCH_VALID_o = 1'b0;
    end else if (r_tgt_err) begin
      S_AXI_RCH_o       = E_AXI_RCH_i;
      S_AXI_RCH_VALID_o = E_AXI_RCH_VALID_i;
      E_AXI_RCH_READY_o = S_AXI_RCH_READY_i;
    end else begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (r_tgt_idx == IDX_W'(i)) begin
          S_AXI_RCH_o          = M_AXI_RCH_i[i*AXI_RDCHAN_WIDTH +: AXI_RDCHAN_WIDTH];
          S_AXI_RCH_VALID_o    = M_AXI_RCH_VALID_i[i];
          M_AXI_RCH_READY_o[i] = S_AXI_RCH_READY_i;
        end else begin
          M_AXI_RCH_READY_o[i] = 1'b0;
        end
      end
    end
  end

  // Master AR ready: high in every cycle the FSM sits in IDLE, except the first after reset
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_ar_ready <= 1'b0;
    end else begin
      r_ar_ready <= (w_next_state == ST_IDLE);
    end
  end

  // AR payload and decoded target capture
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_ar_payload <= '0;
      r_tgt_err    <= 1'b0;
      r_tgt_idx    <= '0;
    end else if (w_ar_cap) begin
      r_ar_payload <= S_AXI_ARCH_i;
      r_tgt_err    <= ~w_dec_hit;
      r_tgt_idx    <= w_dec_idx;
    end else begin
      r_ar_payload <= r_ar_payload;
      r_tgt_err    <= r_tgt_err;
      r_tgt_idx    <= r_tgt_idx;
    end
  end

  // Downstream AR valids: raised on capture, cleared on the target's AR handshake
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_m_ar_valid <= '0;
      r_e_ar_valid <= 1'b0;
    end else if (w_ar_cap) begin
      r_m_ar_valid <= w_dec_hit ? (NUM_SLAVES'(1) << w_dec_idx) : '0;
      r_e_ar_valid <= ~w_dec_hit;
    end else if (w_ar_hs) begin
      r_m_ar_valid <= '0;
      r_e_ar_valid <= 1'b0;
    end else begin
      r_m_ar_valid <= r_m_ar_valid;
      r_e_ar_valid <= r_e_ar_valid;
    end
  end

  // Saturating misroute counter
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_misroute_cnt <= 8'h00;
    end else if (w_ar_cap && !w_dec_hit && (r_misroute_cnt != 8'hFF)) begin
      r_misroute_cnt <= r_misroute_cnt + 8'h01;
    end else begin
      r_misroute_cnt <= r_misroute_cnt;
    end
  end

  assign S_AXI_ARCH_READY_o = r_ar_ready;
  assign M_AXI_ARCH_o       = {NUM_SLAVES{r_ar_payload}};
  assign M_AXI_ARCH_VALID_o = r_m_ar_valid;
  assign E_AXI_ARCH_o       = r_ar_payload;
  assign E_AXI_ARCH_VALID_o = r_e_ar_valid;
  assign MISROUTE_CNT_o     = r_misroute_cnt;

endmodule

// File: tb/tb_axi_r_addr_decoder.sv
// Scoreboard bench for axi_r_addr_decoder: expected R beats are queued as stimulus is driven
// and compared against beats the master accepts.
module tb_axi_r_addr_decoder;

  localparam int N   = 2;
  localparam int ARW = 1 + 8 + 8 + 3 + 2;
  localparam int RDW = 32 + 2 + 1 + 1;

  logic             ACLK;
  logic             ARESET;
  logic [ARW-1:0]   S_AXI_ARCH_i;
  logic             S_AXI_ARCH_VALID_i;
  logic             S_AXI_ARCH_READY_o;
  logic [RDW-1:0]   S_AXI_RCH_o;
  logic             S_AXI_RCH_VALID_o;
  logic             S_AXI_RCH_READY_i;
  logic [N*ARW-1:0] M_AXI_ARCH_o;
  logic [N-1:0]     M_AXI_ARCH_VALID_o;
  logic [N-1:0]     M_AXI_ARCH_READY_i;
  logic [N*RDW-1:0] M_AXI_RCH_i;
  logic [N-1:0]     M_AXI_RCH_VALID_i;
  logic [N-1:0]     M_AXI_RCH_READY_o;
  logic [ARW-1:0]   E_AXI_ARCH_o;
  logic             E_AXI_ARCH_VALID_o;
  logic             E_AXI_ARCH_READY_i;
  logic [RDW-1:0]   E_AXI_RCH_i;
  logic             E_AXI_RCH_VALID_i;
  logic             E_AXI_RCH_READY_o;
  logic [7:0]       MISROUTE_CNT_o;

  int checks   = 0;
  int failures = 0;
  logic [RDW-1:0] exp_q[$];
  logic [RDW-1:0] obs_q[$];

  axi_r_addr_decoder dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_ARCH_i(S_AXI_ARCH_i), .S_AXI_ARCH_VALID_i(S_AXI_ARCH_VALID_i),
    .S_AXI_ARCH_READY_o(S_AXI_ARCH_READY_o),
    .S_AXI_RCH_o(S_AXI_RCH_o), .S_AXI_RCH_VALID_o(S_AXI_RCH_VALID_o),
    .S_AXI_RCH_READY_i(S_AXI_RCH_READY_i),
    .M_AXI_ARCH_o(M_AXI_ARCH_o), .M_AXI_ARCH_VALID_o(M_AXI_ARCH_VALID_o),
    .M_AXI_ARCH_READY_i(M_AXI_ARCH_READY_i),
    .M_AXI_RCH_i(M_AXI_RCH_i), .M_AXI_RCH_VALID_i(M_AXI_RCH_VALID_i),
    .M_AXI_RCH_READY_o(M_AXI_RCH_READY_o),
    .E_AXI_ARCH_o(E_AXI_ARCH_o), .E_AXI_ARCH_VALID_o(E_AXI_ARCH_VALID_o),
    .E_AXI_ARCH_READY_i(E_AXI_ARCH_READY_i),
    .E_AXI_RCH_i(E_AXI_RCH_i), .E_AXI_RCH_VALID_i(E_AXI_RCH_VALID_i),
    .E_AXI_RCH_READY_o(E_AXI_RCH_READY_o),
    .MISROUTE_CNT_o(MISROUTE_CNT_o)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Beats the master will accept on the coming edge
  always @(negedge ACLK) begin
    if (!ARESET && S_AXI_RCH_VALID_o && S_AXI_RCH_READY_i) obs_q.push_back(S_AXI_RCH_o);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [ARW-1:0] mk_ar(input logic id, input logic [7:0] len, input logic [7:0] addr);
    return {id, len, addr, 3'd2, 2'b01};
  endfunction

  function automatic logic [RDW-1:0] mk_r(input logic [31:0] d, input logic [1:0] resp,
                                          input logic last, input logic id);
    return {d, resp, last, id};
  endfunction

  task automatic step_cycle();
    @(posedge ACLK);
    #1;
  endtask

  // Present an AR to the master port and hold it until accepted (bounded)
  task automatic issue_ar(input logic [ARW-1:0] ar);
    int n;
    step_cycle();
    S_AXI_ARCH_i       = ar;
    S_AXI_ARCH_VALID_i = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge ACLK);
      if (S_AXI_ARCH_READY_o) break;
      step_cycle();
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL ar_accept_timeout got=ready_low exp=ready_high");
    end
    step_cycle();
    S_AXI_ARCH_VALID_i = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    step_cycle();
    @(negedge ACLK);
    checks++;
    if ({S_AXI_ARCH_READY_o, S_AXI_RCH_VALID_o, M_AXI_ARCH_VALID_o, M_AXI_RCH_READY_o,
         E_AXI_ARCH_VALID_o, E_AXI_RCH_READY_o} !== 8'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {S_AXI_ARCH_READY_o, S_AXI_RCH_VALID_o,
               M_AXI_ARCH_VALID_o, M_AXI_RCH_READY_o, E_AXI_ARCH_VALID_o, E_AXI_RCH_READY_o});
    end
    checks++;
    if (MISROUTE_CNT_o !== 8'h00 || E_AXI_ARCH_o !== '0) begin
      failures++;
      $display("FAIL reset_regs got cnt=%h ar=%h exp=0", MISROUTE_CNT_o, E_AXI_ARCH_o);
    end
    step_cycle();
    ARESET = 1'b0;
    @(negedge ACLK);
    checks++;
    if (S_AXI_ARCH_READY_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_early got=%b exp=0", S_AXI_ARCH_READY_o);
    end
    step_cycle();
    @(negedge ACLK);
    checks++;
    if (S_AXI_ARCH_READY_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_rise got=%b exp=1", S_AXI_ARCH_READY_o);
    end
  endtask

  task automatic test_slave_read();
    logic [ARW-1:0] ar;
    logic [RDW-1:0] e, o;
    ar = mk_ar(1'b1, 8'd3, 8'h10);
    S_AXI_RCH_READY_i = 1'b1;
    issue_ar(ar);
    @(negedge ACLK);
    checks++;
    if (M_AXI_ARCH_VALID_o !== 2'b01 || E_AXI_ARCH_VALID_o !== 1'b0 || S_AXI_ARCH_READY_o !== 1'b0) begin
      failures++;
      $display("FAIL t1_ar_valid got m=%b e=%b rdy=%b exp m=01 e=0 rdy=0",
               M_AXI_ARCH_VALID_o, E_AXI_ARCH_VALID_o, S_AXI_ARCH_READY_o);
    end
    checks++;
    if (M_AXI_ARCH_o[0 +: ARW] !== ar) begin
      failures++;
      $display("FAIL t1_ar_payload got=%h exp=%h", M_AXI_ARCH_o[0 +: ARW], ar);
    end
    step_cycle();
    M_AXI_ARCH_READY_i = 2'b01;
    step_cycle();
    M_AXI_ARCH_READY_i = 2'b00;
    for (int b = 0; b < 4; b++) begin
      M_AXI_RCH_i[0 +: RDW] = mk_r(32'hA000_0000 + 32'(b), 2'b00, (b == 3), 1'b1);
      M_AXI_RCH_VALID_i[0]  = 1'b1;
      exp_q.push_back(M_AXI_RCH_i[0 +: RDW]);
      @(negedge ACLK);
      if (b == 0) begin
        checks++;
        if (M_AXI_ARCH_VALID_o !== 2'b00) begin
          failures++;
          $display("FAIL t1_ar_valid_drop got=%b exp=00", M_AXI_ARCH_VALID_o);
        end
      end
      step_cycle();
    end
    M_AXI_RCH_VALID_i[0] = 1'b0;
    @(negedge ACLK);
    checks++;
    if (S_AXI_ARCH_READY_o !== 1'b1) begin
      failures++;
      $display("FAIL t1_ready_after_last got=%b exp=1", S_AXI_ARCH_READY_o);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t1_beat_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL t1_beat got=%h exp=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_misroute();
    logic [ARW-1:0] ar;
    logic [RDW-1:0] e, o;
    logic [RDW-1:0] beat0;
    ar    = mk_ar(1'b0, 8'd1, 8'h90);
    beat0 = mk_r(32'h0E0E_0001, 2'b00, 1'b0, 1'b0);
    step_cycle();
    S_AXI_RCH_READY_i = 1'b0;
    E_AXI_RCH_i       = beat0;
    E_AXI_RCH_VALID_i = 1'b1;
    @(negedge ACLK);
    checks++;
    if (S_AXI_RCH_VALID_o !== 1'b0 || E_AXI_RCH_READY_o !== 1'b0) begin
      failures++;
      $display("FAIL t2_idle_block got v=%b r=%b exp v=0 r=0", S_AXI_RCH_VALID_o, E_AXI_RCH_READY_o);
    end
    issue_ar(ar);
    @(negedge ACLK);
    checks++;
    if (E_AXI_ARCH_VALID_o !== 1'b1 || M_AXI_ARCH_VALID_o !== 2'b00 || E_AXI_ARCH_o !== ar) begin
      failures++;
      $display("FAIL t2_e_ar got v=%b m=%b ar=%h exp v=1 m=00 ar=%h",
               E_AXI_ARCH_VALID_o, M_AXI_ARCH_VALID_o, E_AXI_ARCH_o, ar);
    end
    checks++;
    if (S_AXI_RCH_VALID_o !== 1'b1 || S_AXI_RCH_o !== beat0) begin
      failures++;
      $display("FAIL t2_issue_route got v=%b d=%h exp v=1 d=%h", S_AXI_RCH_VALID_o, S_AXI_RCH_o, beat0);
    end
    step_cycle();
    S_AXI_RCH_READY_i = 1'b1;
    exp_q.push_back(beat0);
    @(negedge ACLK);
    checks++;
    if (E_AXI_RCH_READY_o !== 1'b1) begin
      failures++;
      $display("FAIL t2_e_rready got=%b exp=1", E_AXI_RCH_READY_o);
    end
    step_cycle();
    E_AXI_RCH_i        = mk_r(32'h0E0E_0002, 2'b11, 1'b1, 1'b0);
    E_AXI_ARCH_READY_i = 1'b1;
    exp_q.push_back(E_AXI_RCH_i);
    step_cycle();
    E_AXI_RCH_VALID_i  = 1'b0;
    E_AXI_ARCH_READY_i = 1'b0;
    @(negedge ACLK);
    checks++;
    if (MISROUTE_CNT_o !== 8'd1 || S_AXI_ARCH_READY_o !== 1'b1 || E_AXI_ARCH_VALID_o !== 1'b0) begin
      failures++;
      $display("FAIL t2_done got cnt=%0d rdy=%b ev=%b exp cnt=1 rdy=1 ev=0",
               MISROUTE_CNT_o, S_AXI_ARCH_READY_o, E_AXI_ARCH_VALID_o);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t2_beat_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL t2_beat got=%h exp=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [RDW-1:0] e, o;
    logic [RDW-1:0] beat1;
    S_AXI_RCH_READY_i = 1'b1;
    issue_ar(mk_ar(1'b1, 8'd3, 8'h20));
    step_cycle();
    M_AXI_ARCH_READY_i = 2'b01;
    step_cycle();
    M_AXI_ARCH_READY_i = 2'b00;
    M_AXI_RCH_i[0 +: RDW] = mk_r(32'hB000_0000, 2'b00, 1'b0, 1'b1);
    M_AXI_RCH_VALID_i[0]  = 1'b1;
    exp_q.push_back(M_AXI_RCH_i[0 +: RDW]);
    step_cycle();
    beat1 = mk_r(32'hB000_0001, 2'b01, 1'b0, 1'b1);
    M_AXI_RCH_i[0 +: RDW] = beat1;
    exp_q.push_back(beat1);
    S_AXI_RCH_READY_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      checks++;
      if (M_AXI_RCH_READY_o[0] !== 1'b0 || S_AXI_RCH_VALID_o !== 1'b1 || S_AXI_RCH_o !== beat1) begin
        failures++;
        $display("FAIL t3_stall got rr=%b v=%b d=%h exp rr=0 v=1 d=%h",
                 M_AXI_RCH_READY_o[0], S_AXI_RCH_VALID_o, S_AXI_RCH_o, beat1);
      end
      step_cycle();
    end
    S_AXI_RCH_READY_i = 1'b1;
    step_cycle();
    for (int b = 2; b < 4; b++) begin
      M_AXI_RCH_i[0 +: RDW] = mk_r(32'hB000_0000 + 32'(b), 2'b00, (b == 3), 1'b1);
      exp_q.push_back(M_AXI_RCH_i[0 +: RDW]);
      step_cycle();
    end
    M_AXI_RCH_VALID_i[0] = 1'b0;
    @(negedge ACLK);
    checks++;
    if (S_AXI_ARCH_READY_o !== 1'b1) begin
      failures++;
      $display("FAIL t3_ready_after_last got=%b exp=1", S_AXI_ARCH_READY_o);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t3_beat_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL t3_beat got=%h exp=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_nontarget();
    logic [RDW-1:0] e, o;
    S_AXI_RCH_READY_i       = 1'b1;
    M_AXI_RCH_i[RDW +: RDW] = mk_r(32'hDEAD_BEEF, 2'b10, 1'b1, 1'b0);
    M_AXI_RCH_VALID_i[1]    = 1'b1;
    M_AXI_RCH_i[0 +: RDW]   = '0;
    issue_ar(mk_ar(1'b0, 8'd1, 8'h04));
    step_cycle();
    M_AXI_ARCH_READY_i = 2'b01;
    step_cycle();
    M_AXI_ARCH_READY_i = 2'b00;
    @(negedge ACLK);
    checks++;
    if (S_AXI_RCH_VALID_o !== 1'b0 || M_AXI_RCH_READY_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL t4_nontarget_idle got v=%b rr1=%b exp v=0 rr1=0", S_AXI_RCH_VALID_o, M_AXI_RCH_READY_o[1]);
    end
    for (int b = 0; b < 2; b++) begin
      step_cycle();
      M_AXI_RCH_i[0 +: RDW] = mk_r(32'hC000_0000 + 32'(b), 2'b00, (b == 1), 1'b0);
      M_AXI_RCH_VALID_i[0]  = 1'b1;
      exp_q.push_back(M_AXI_RCH_i[0 +: RDW]);
      @(negedge ACLK);
      checks++;
      if (M_AXI_RCH_READY_o !== 2'b01 || S_AXI_RCH_o !== M_AXI_RCH_i[0 +: RDW]) begin
        failures++;
        $display("FAIL t4_route got rr=%b d=%h exp rr=01 d=%h", M_AXI_RCH_READY_o, S_AXI_RCH_o,
                 M_AXI_RCH_i[0 +: RDW]);
      end
    end
    step_cycle();
    M_AXI_RCH_VALID_i = 2'b00;
    @(negedge ACLK);
    checks++;
    if (S_AXI_ARCH_READY_o !== 1'b1) begin
      failures++;
      $display("FAIL t4_ready_after_last got=%b exp=1", S_AXI_ARCH_READY_o);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t4_beat_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL t4_beat got=%h exp=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [RDW-1:0] e, o;
    S_AXI_RCH_READY_i = 1'b1;
    issue_ar(mk_ar(1'b1, 8'd3, 8'h30));
    step_cycle();
    M_AXI_ARCH_READY_i = 2'b01;
    step_cycle();
    M_AXI_ARCH_READY_i = 2'b00;
    for (int b = 0; b < 2; b++) begin
      M_AXI_RCH_i[0 +: RDW] = mk_r(32'hD000_0000 + 32'(b), 2'b00, 1'b0, 1'b1);
      M_AXI_RCH_VALID_i[0]  = 1'b1;
      exp_q.push_back(M_AXI_RCH_i[0 +: RDW]);
      step_cycle();
    end
    M_AXI_RCH_i[0 +: RDW] = mk_r(32'hD000_0002, 2'b00, 1'b0, 1'b1);
    #2;
    ARESET = 1'b1;
    @(negedge ACLK);
    checks++;
    if ({S_AXI_ARCH_READY_o, S_AXI_RCH_VALID_o, M_AXI_ARCH_VALID_o, M_AXI_RCH_READY_o,
         E_AXI_ARCH_VALID_o, E_AXI_RCH_READY_o} !== 8'b0 || MISROUTE_CNT_o !== 8'h00) begin
      failures++;
      $display("FAIL t5_in_reset got=%b cnt=%h exp=0", {S_AXI_ARCH_READY_o, S_AXI_RCH_VALID_o,
               M_AXI_ARCH_VALID_o, M_AXI_RCH_READY_o, E_AXI_ARCH_VALID_o, E_AXI_RCH_READY_o}, MISROUTE_CNT_o);
    end
    step_cycle();
    M_AXI_RCH_VALID_i = 2'b00;
    ARESET = 1'b0;
    @(negedge ACLK);
    checks++;
    if (S_AXI_ARCH_READY_o !== 1'b0) begin
      failures++;
      $display("FAIL t5_ready_early got=%b exp=0", S_AXI_ARCH_READY_o);
    end
    step_cycle();
    @(negedge ACLK);
    checks++;
    if (S_AXI_ARCH_READY_o !== 1'b1) begin
      failures++;
      $display("FAIL t5_ready_rise got=%b exp=1", S_AXI_ARCH_READY_o);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t5_beat_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL t5_beat got=%h exp=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [RDW-1:0] e, o;
    logic [7:0]     exp_cnt;
    logic           kid;
    S_AXI_RCH_READY_i = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      kid = k[0];
      issue_ar(mk_ar(kid, 8'd0, 8'h80 + 8'(k % 128)));
      if (k == 254 || k == 255 || k == 260) begin
        exp_cnt = (k >= 255) ? 8'hFF : 8'(k);
        checks++;
        if (MISROUTE_CNT_o !== exp_cnt) begin
          failures++;
          $display("FAIL t6_cnt k=%0d got=%h exp=%h", k, MISROUTE_CNT_o, exp_cnt);
        end
      end
      E_AXI_RCH_i        = mk_r(32'(k), 2'b11, 1'b1, kid);
      E_AXI_RCH_VALID_i  = 1'b1;
      E_AXI_ARCH_READY_i = 1'b1;
      exp_q.push_back(E_AXI_RCH_i);
      step_cycle();
      E_AXI_RCH_VALID_i  = 1'b0;
      E_AXI_ARCH_READY_i = 1'b0;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t6_beat_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL t6_beat got=%h exp=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    ARESET             = 1'b1;
    S_AXI_ARCH_i       = '0;
    S_AXI_ARCH_VALID_i = 1'b0;
    S_AXI_RCH_READY_i  = 1'b0;
    M_AXI_ARCH_READY_i = '0;
    M_AXI_RCH_i        = '0;
    M_AXI_RCH_VALID_i  = '0;
    E_AXI_ARCH_READY_i = 1'b0;
    E_AXI_RCH_i        = '0;
    E_AXI_RCH_VALID_i  = 1'b0;
    test_reset();
    test_slave_read();
    test_misroute();
    test_backpressure();
    test_nontarget();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
